binary_frame_streamer: RTL



---
 rtl/binary_frame_streamer_pkg.sv | 25 ++
 rtl/binary_frame_streamer_if.sv | 37 +++
 rtl/binary_frame_streamer_raster_counter.sv | 42 ++++
 rtl/binary_frame_streamer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/binary_frame_streamer_pkg.sv
// Shared gesture-pipeline constants (image geometry, coordinate width) and the
// frame streamer's state encoding.
package binary_frame_streamer_pkg;

    localparam int GEST_IMG_W   = 160;
    localparam int GEST_IMG_H   = 120;
    localparam int GEST_COORD_W = 8;

    localparam int BFS_WORD_W = 16;
    localparam int BFS_ADDR_W = 11;

    typedef logic [2:0] bfs_state_t;

    localparam bfs_state_t ST_IDLE   = 3'd0;
    localparam bfs_state_t ST_FETCH  = 3'd1;
    localparam bfs_state_t ST_LOAD   = 3'd2;
    localparam bfs_state_t ST_STREAM = 3'd3;
    localparam bfs_state_t ST_FINISH = 3'd4;

    // Number of memory words holding one packed 1-bit frame.
    function automatic int frame_words(input int img_w, input int img_h, input int word_w);
        return (img_w * img_h) / word_w;
    endfunction

endpackage

// File: rtl/binary_frame_streamer_if.sv
// Frame-memory read port and pixel stream bundle between the frame streamer
// (master) and the memory / downstream feature extractor (slave).
interface binary_frame_streamer_if
    import binary_frame_streamer_pkg::*;
#(
    parameter int ADDR_W  = BFS_ADDR_W,
    parameter int WORD_W  = BFS_WORD_W,
    parameter int COORD_W = GEST_COORD_W
);

    logic               mem_rd;
    logic [ADDR_W-1:0]  mem_addr;
    logic [WORD_W-1:0]  mem_rdata;

    logic               pix_valid;
    logic               pix_ready;
    logic               pix_data;
    logic               pix_sof;
    logic               pix_eol;
    logic [COORD_W-1:0] pix_row;
    logic [COORD_W-1:0] pix_col;

    modport master (
        output mem_rd, mem_addr,
        input  mem_rdata,
        output pix_valid, pix_data, pix_sof, pix_eol, pix_row, pix_col,
        input  pix_ready
    );

    modport slave (
        input  mem_rd, mem_addr,
        output mem_rdata,
        input  pix_valid, pix_data, pix_sof, pix_eol, pix_row, pix_col,
        output pix_ready
    );

endinterface

// File: rtl/binary_frame_streamer_raster_counter.sv
// Raster row/column counter with wrap and frame-position flags; also reused
// by the palm identification stage.
module raster_counter
    import binary_frame_streamer_pkg::*;
#(
    parameter int IMG_W   = GEST_IMG_W,
    parameter int IMG_H   = GEST_IMG_H,
    parameter int COORD_W = GEST_COORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               adv,
    output logic [COORD_W-1:0] row,
    output logic [COORD_W-1:0] col,
    output logic               sof,
    output logic               eol,
    output logic               last
);

    localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(IMG_H - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign sof  = (row == '0) && (col == '0);
    assign eol  = (col == COL_LAST);
    assign last = eol && (row == ROW_LAST);

endmodule

// File: rtl/binary_frame_streamer.sv
// Replays a stored 1-bit frame from word-wide memory as a raster pixel stream.
// Build option FRAME_STREAM_PREFETCH_EN overlaps the next word read with streaming.
//
//   state  | meaning
//   IDLE   | waiting for start
//   FETCH  | issue memory read for the next word
//   LOAD   | read data returns, captured into the shift register
//   STREAM | present shift_reg[0] as a pixel beat, shift on each transfer
//   FINISH | one-cycle done pulse, then back to IDLE
module binary_frame_streamer
    import binary_frame_streamer_pkg::*;
#(
    parameter int IMG_W  = GEST_IMG_W,
    parameter int IMG_H  = GEST_IMG_H,
    parameter int WORD_W = BFS_WORD_W,
    parameter int ADDR_W = BFS_ADDR_W
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    binary_frame_streamer_if.master bus
);

    localparam int BIT_W = $clog2(WORD_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

    bfs_state_t state;
    bfs_state_t state_nxt;

    logic [ADDR_W:0]         word_cnt;
    logic [WORD_W-1:0]       shift_reg;
    logic [WORD_W-1:0]       pf_word;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    streaming;
    logic                    xfer;
    logic                    word_end;
    logic                    frame_start;
    logic                    fetch_rd;
    logic                    pf_rd;
    logic                    rd;
    logic                    reload;
    logic [GEST_COORD_W-1:0] rc_row;
    logic [GEST_COORD_W-1:0] rc_col;
    logic                    rc_sof;
    logic                    rc_eol;
    logic                    rc_last;

    assign frame_start = (state == ST_IDLE) && start;
    assign streaming   = (state == ST_STREAM);
    assign xfer        = streaming && bus.pix_ready;
    assign word_end    = (bit_cnt == BIT_LAST);
    assign fetch_rd    = (state == ST_FETCH);
    assign rd          = fetch_rd || pf_rd;

    raster_counter #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .COORD_W (GEST_COORD_W)
    ) u_raster (
        .clk  (clk),
        .rst  (rst),
        .clr  (frame_start),
        .adv  (xfer),
        .row  (rc_row),
        .col  (rc_col),
        .sof  (rc_sof),
        .eol  (rc_eol),
        .last (rc_last)
    );

`ifdef FRAME_STREAM_PREFETCH_EN
    localparam int WORDS = frame_words(IMG_W, IMG_H, WORD_W);
    localparam logic [ADDR_W:0] WORDS_C = (ADDR_W + 1)'(WORDS);

    logic pf_valid;
    logic pf_pend;

    // word_cnt already points past the streaming word, so reaching WORDS_C
    // means the current word is the last one and nothing is left to prefetch.
    assign pf_rd  = streaming && (bit_cnt == '0) && !pf_valid && !pf_pend
                    && (word_cnt != WORDS_C);
    assign reload = pf_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            pf_valid <= 1'b0;
            pf_pend  <= 1'b0;
            pf_word  <= '0;
        end else begin
            pf_pend <= pf_rd;
            if (state == ST_IDLE) begin
                pf_valid <= 1'b0;
            end else if (pf_pend) begin
                pf_word  <= bus.mem_rdata;
                pf_valid <= 1'b1;
            end else if (xfer && word_end) begin
                pf_valid <= 1'b0;
            end
        end
    end
`else
    assign pf_rd   = 1'b0;
    assign reload  = 1'b0;
    assign pf_word = '0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_FETCH;
            ST_FETCH:  state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = ST_STREAM;
            ST_STREAM: begin
                if (xfer) begin
                    if (rc_last)
                        state_nxt = ST_FINISH;
                    else if (word_end && !reload)
                        state_nxt = ST_FETCH;
                end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            word_cnt  <= '0;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            state <= state_nxt;

            if (frame_start)
                word_cnt <= '0;
            else if (rd)
                word_cnt <= word_cnt + (ADDR_W + 1)'(1);

            // Shifting in zeros leaves the register clear once a frame ends.
            if (state == ST_LOAD)
                shift_reg <= bus.mem_rdata;
            else if (xfer && word_end && reload)
                shift_reg <= pf_word;
            else if (xfer)
                shift_reg <= {1'b0, shift_reg[WORD_W-1:1]};

            if (frame_start)
                bit_cnt <= '0;
            else if (xfer)
                bit_cnt <= word_end ? '0 : bit_cnt + BIT_W'(1);
        end
    end

    assign busy = (state == ST_FETCH) || (state == ST_LOAD) || streaming;
    assign done = (state == ST_FINISH);

    assign bus.mem_rd   = rd;
    assign bus.mem_addr = rd ? word_cnt[ADDR_W-1:0] : '0;

    assign bus.pix_valid = streaming;
    assign bus.pix_data  = streaming && shift_reg[0];
    assign bus.pix_sof   = streaming && rc_sof;
    assign bus.pix_eol   = streaming && rc_eol;
    assign bus.pix_row   = rc_row;
    assign bus.pix_col   = rc_col;

endmodule
